dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Shares the single data-memory port between the CPU memory stage and the UART program loader. Grants one requester per cycle, steers write enables and addresses to the memory, and routes synchronous read data back to the owner one cycle later. CPU has priority; a starvation counter guarantees the loader forward progress. Sits between the memory-stage decode logic and the data memory block.

## Interface
- AW, 12: word-address width of the data memory.
- STARVE_LIMIT, 8: consecutive denied loader cycles before a forced loader grant (1..255).

- clk  in  1  system clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- cpu_req  in  1  CPU access request this cycle.
- cpu_wea  in  4  CPU byte write enables; 0 = read.
- cpu_addr  in  AW  CPU word address.
- cpu_wdata  in  32  CPU write data.
- cpu_stall  out  1  CPU request not granted this cycle; hold request.
- cpu_rdata  out  32  read data for CPU.
- cpu_rvalid  out  1  cpu_rdata valid (one cycle after a granted CPU read).
- ldr_req  in  1  loader access request.
- ldr_wea  in  4  loader byte write enables; 0 = read.
- ldr_addr  in  AW  loader word address.
- ldr_wdata  in  32  loader write data.
- ldr_gnt  out  1  loader request accepted this cycle.
- ldr_rdata  out  32  read data for loader.
- ldr_rvalid  out  1  ldr_rdata valid.
- mem_en  out  1  memory port enable.
- mem_wea  out  4  memory byte write enables.
- mem_addr  out  AW  memory address.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data, registered, 1-cycle latency.

## Operation
- FSM states: S_CPU (CPU priority), S_LDR (forced loader grant).
- S_CPU: cpu_req → CPU granted; else ldr_req → loader granted; else idle (mem_en=0, mem_wea=0).
- S_LDR: ldr_req → loader granted, CPU stalled if requesting; next state S_CPU. If ldr_req dropped, CPU-priority rules apply, next S_CPU.
- S_CPU → S_LDR when starve counter reaches STARVE_LIMIT-1 and loader is denied again this cycle.
- Starve counter (8 bit): increments each cycle ldr_req=1 and ldr_gnt=0; clears on loader grant or ldr_req=0; saturates, never wraps.
- Grant muxes requester's wea/addr/wdata onto mem_*; mem_en = any grant.
- cpu_stall = cpu_req & ~cpu_grant; ldr_gnt = loader grant.
- Return tracking: register `owner` (NONE/CPU/LDR) set on a granted read (wea=0), NONE otherwise. cpu_rvalid = (owner==CPU); ldr_rvalid = (owner==LDR). cpu_rdata and ldr_rdata both driven from mem_rdata.
- Writes produce no rvalid.

## Timing
- Grant, stall, mem_* are combinational from same-cycle requests and state.
- Read latency: rvalid exactly 1 cycle after grant; back-to-back reads from either requester sustain 1 access/cycle.
- Reset values: state S_CPU, counter 0, owner NONE; cpu_rvalid=0, ldr_rvalid=0. With requests low, all grant/mem outputs 0.
- Reset asserted mid-read: owner cleared; no rvalid in the following cycle.
- Simultaneous requests in S_CPU below limit: CPU wins, loader held.
- Requests change only while not stalled; arbiter does not latch requests.

## Configuration
- DMEM_ARB_STARVE_EN defined: starve counter and S_LDR present as above.
- Undefined: strict CPU priority; FSM and counter removed; loader granted only when cpu_req=0; STARVE_LIMIT ignored.

## Test plan
- After rst, ldr_req=1 read addr 0x010, cpu_req=0 → ldr_gnt=1, mem_addr=0x010, next cycle ldr_rvalid=1 with mem_rdata.
- cpu_req=1 write wea=4'hF addr 0x020 data 0xDEADBEEF, ldr_req=1 → mem_wea=4'hF, mem_wdata=0xDEADBEEF, cpu_stall=0, ldr_gnt=0, no rvalid next cycle.
- cpu_req and ldr_req held high, STARVE_LIMIT=8 → loader denied 8 cycles, 9th cycle ldr_gnt=1 and cpu_stall=1, 10th cycle CPU granted, counter 0.
- Same as above with DMEM_ARB_STARVE_EN undefined → ldr_gnt stays 0 for 50 cycles.
- CPU read granted, rst asserted next edge → cpu_rvalid=0 in following cycle, state S_CPU.
- Alternating CPU read/loader read each cycle → rvalid alternates cpu/ldr, one per cycle, data matches address order.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//
// Shares the single data-memory port between the CPU memory stage and the
// UART program loader. One requester is granted per cycle. The grant steers
// that requester's write enables, address and write data onto the memory
// port. Synchronous read data comes back one cycle later, and a valid strobe
// marks it for whoever issued the read.
//
// The CPU normally has priority. When the build defines DMEM_ARB_STARVE_EN,
// a starvation counter forces a loader grant after STARVE_LIMIT consecutive
// denied loader cycles. Without that macro the arbitration is strict CPU
// priority, and STARVE_LIMIT is only range-checked.
//
// Parameters:
//   AW            word-address width of the data memory
//   STARVE_LIMIT  denied loader cycles before a forced loader grant (1..255)
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   cpu_req/wea/addr/wdata    CPU access request (wea == 0 means read)
//   cpu_stall                 CPU request not granted this cycle
//   cpu_rdata, cpu_rvalid     CPU read return (one cycle after grant)
//   ldr_req/wea/addr/wdata    loader access request (wea == 0 means read)
//   ldr_gnt                   loader request accepted this cycle
//   ldr_rdata, ldr_rvalid     loader read return
//   mem_en/wea/addr/wdata     memory port command
//   mem_rdata                 registered memory read data
module dmem_arbiter #(
    parameter int AW           = 12,
    parameter int STARVE_LIMIT = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic [3:0]    cpu_wea,
    input  logic [AW-1:0] cpu_addr,
    input  logic [31:0]   cpu_wdata,
    output logic          cpu_stall,
    output logic [31:0]   cpu_rdata,
    output logic          cpu_rvalid,
    input  logic          ldr_req,
    input  logic [3:0]    ldr_wea,
    input  logic [AW-1:0] ldr_addr,
    input  logic [31:0]   ldr_wdata,
    output logic          ldr_gnt,
    output logic [31:0]   ldr_rdata,
    output logic          ldr_rvalid,
    output logic          mem_en,
    output logic [3:0]    mem_wea,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata
);

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_CPU,
        OWN_LDR
    } owner_t;

    logic   cpu_grant;
    logic   ldr_grant;
    owner_t owner;

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_bad_limit
        $error("dmem_arbiter: STARVE_LIMIT must be in 1..255");
    end

`ifdef DMEM_ARB_STARVE_EN
    typedef enum logic {
        S_CPU,
        S_LDR
    } state_t;

    localparam logic [7:0] LIMIT_M1 = 8'(STARVE_LIMIT - 1);

    state_t     state;
    state_t     state_next;
    logic [7:0] starve_cnt;
    logic [7:0] starve_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_CPU;
            starve_cnt <= 8'd0;
        end else begin
            state      <= state_next;
            starve_cnt <= starve_next;
        end
    end

    // S_LDR lasts for exactly one cycle. If the loader has dropped its
    // request by then, ordinary CPU-priority arbitration applies.
    always_comb begin
        cpu_grant   = 1'b0;
        ldr_grant   = 1'b0;
        state_next  = S_CPU;
        starve_next = 8'd0;

        if (state == S_LDR && ldr_req) begin
            ldr_grant = 1'b1;
        end else if (cpu_req) begin
            cpu_grant = 1'b1;
        end else if (ldr_req) begin
            ldr_grant = 1'b1;
        end

        // The counter saturates at 8'hFF rather than wrapping. A wrap
        // would silently restart the starvation window.
        if (ldr_req && !ldr_grant) begin
            starve_next = (starve_cnt == 8'hFF) ? starve_cnt : starve_cnt + 8'd1;
            if (state == S_CPU && starve_cnt >= LIMIT_M1) begin
                state_next = S_LDR;
            end
        end
    end
`else
    // Strict CPU priority: the loader only gets cycles the CPU leaves idle.
    always_comb begin
        cpu_grant = cpu_req;
        ldr_grant = ldr_req & ~cpu_req;
    end
`endif

    // Steer the granted requester onto the memory port. Drive zeros when
    // the port is idle so nothing stray reaches the memory.
    always_comb begin
        mem_en    = cpu_grant | ldr_grant;
        mem_wea   = 4'h0;
        mem_addr  = '0;
        mem_wdata = 32'h0;
        if (cpu_grant) begin
            mem_wea   = cpu_wea;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (ldr_grant) begin
            mem_wea   = ldr_wea;
            mem_addr  = ldr_addr;
            mem_wdata = ldr_wdata;
        end
    end

    // Remember who issued the read so the returning data is marked valid
    // for that requester only. Writes leave no owner behind.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner <= OWN_NONE;
        end else if (cpu_grant && cpu_wea == 4'h0) begin
            owner <= OWN_CPU;
        end else if (ldr_grant && ldr_wea == 4'h0) begin
            owner <= OWN_LDR;
        end else begin
            owner <= OWN_NONE;
        end
    end

    assign cpu_stall  = cpu_req & ~cpu_grant;
    assign ldr_gnt    = ldr_grant;
    assign cpu_rvalid = (owner == OWN_CPU);
    assign ldr_rvalid = (owner == OWN_LDR);
    assign cpu_rdata  = mem_rdata;
    assign ldr_rdata  = mem_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed testbench for dmem_arbiter. A simple registered-read memory model
// returns 0xA0000000 | address for every granted read.
module tb_dmem_arbiter;

    localparam int AW = 12;

    logic          clk;
    logic          rst;
    logic          cpu_req;
    logic [3:0]    cpu_wea;
    logic [AW-1:0] cpu_addr;
    logic [31:0]   cpu_wdata;
    logic          cpu_stall;
    logic [31:0]   cpu_rdata;
    logic          cpu_rvalid;
    logic          ldr_req;
    logic [3:0]    ldr_wea;
    logic [AW-1:0] ldr_addr;
    logic [31:0]   ldr_wdata;
    logic          ldr_gnt;
    logic [31:0]   ldr_rdata;
    logic          ldr_rvalid;
    logic          mem_en;
    logic [3:0]    mem_wea;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    int checks = 0;
    int errors = 0;

    dmem_arbiter #(.AW(AW), .STARVE_LIMIT(8)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_wea(cpu_wea), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata),
        .cpu_rvalid(cpu_rvalid),
        .ldr_req(ldr_req), .ldr_wea(ldr_wea), .ldr_addr(ldr_addr),
        .ldr_wdata(ldr_wdata), .ldr_gnt(ldr_gnt), .ldr_rdata(ldr_rdata),
        .ldr_rvalid(ldr_rvalid),
        .mem_en(mem_en), .mem_wea(mem_wea), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model with a one-cycle read latency. The returned word encodes
    // the address, so the bench can tell which read it belongs to.
    always @(posedge clk) begin
        if (mem_en && mem_wea == 4'h0) begin
            mem_rdata <= 32'hA000_0000 | 32'(mem_addr);
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic creq, input logic [3:0] cwea,
                                 input logic [AW-1:0] caddr, input logic [31:0] cwdata,
                                 input logic lreq, input logic [3:0] lwea,
                                 input logic [AW-1:0] laddr, input logic [31:0] lwdata);
        cpu_req   = creq;
        cpu_wea   = cwea;
        cpu_addr  = caddr;
        cpu_wdata = cwdata;
        ldr_req   = lreq;
        ldr_wea   = lwea;
        ldr_addr  = laddr;
        ldr_wdata = lwdata;
        #1;
    endtask

    task automatic applyIdle;
        applyStimulus(1'b0, 4'h0, '0, 32'h0, 1'b0, 4'h0, '0, 32'h0);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    // Main directed sequence. Inputs are driven 1 ns after the rising edge
    // and checked 1 ns later, well away from the next edge.
    initial begin
        logic exp_gnt;
        int   n_cycles;

        mem_rdata = 32'h0;
        rst = 1'b1;
        applyIdle();
        tick();
        tick();
        rst = 1'b0;
        applyIdle();

        checkOutput("reset cpu_rvalid", 32'(cpu_rvalid), 32'd0);
        checkOutput("reset ldr_rvalid", 32'(ldr_rvalid), 32'd0);
        checkOutput("reset mem_en", 32'(mem_en), 32'd0);
        checkOutput("reset mem_wea", 32'(mem_wea), 32'd0);
        checkOutput("reset ldr_gnt", 32'(ldr_gnt), 32'd0);
        checkOutput("reset cpu_stall", 32'(cpu_stall), 32'd0);

        // The loader reads alone and is granted at once.
        tick();
        applyStimulus(1'b0, 4'h0, '0, 32'h0, 1'b1, 4'h0, 12'h010, 32'h0);
        checkOutput("ldr rd gnt", 32'(ldr_gnt), 32'd1);
        checkOutput("ldr rd mem_en", 32'(mem_en), 32'd1);
        checkOutput("ldr rd mem_addr", 32'(mem_addr), 32'h010);
        tick();
        applyIdle();
        checkOutput("ldr rd rvalid", 32'(ldr_rvalid), 32'd1);
        checkOutput("ldr rd cpu_rvalid", 32'(cpu_rvalid), 32'd0);
        checkOutput("ldr rd data", ldr_rdata, 32'hA000_0010);

        // A CPU write wins against a loader request.
        tick();
        applyStimulus(1'b1, 4'hF, 12'h020, 32'hDEADBEEF, 1'b1, 4'h0, 12'h044, 32'h0);
        checkOutput("cpu wr mem_wea", 32'(mem_wea), 32'hF);
        checkOutput("cpu wr mem_wdata", mem_wdata, 32'hDEADBEEF);
        checkOutput("cpu wr mem_addr", 32'(mem_addr), 32'h020);
        checkOutput("cpu wr cpu_stall", 32'(cpu_stall), 32'd0);
        checkOutput("cpu wr ldr_gnt", 32'(ldr_gnt), 32'd0);
        tick();
        applyIdle();
        checkOutput("cpu wr no cpu_rvalid", 32'(cpu_rvalid), 32'd0);
        checkOutput("cpu wr no ldr_rvalid", 32'(ldr_rvalid), 32'd0);

        // Both requesters hold their requests. With starvation protection,
        // the loader wins every 9th cycle (8 denials, then a forced grant).
        // Without it, the loader never wins.
`ifdef DMEM_ARB_STARVE_EN
        n_cycles = 20;
`else
        n_cycles = 50;
`endif
        for (int c = 1; c <= n_cycles; c++) begin
            tick();
            applyStimulus(1'b1, 4'h0, 12'h030, 32'h0, 1'b1, 4'h0, 12'h040, 32'h0);
`ifdef DMEM_ARB_STARVE_EN
            exp_gnt = (c % 9 == 0);
`else
            exp_gnt = 1'b0;
`endif
            checkOutput($sformatf("starve c%0d ldr_gnt", c), 32'(ldr_gnt), 32'(exp_gnt));
            checkOutput($sformatf("starve c%0d cpu_stall", c), 32'(cpu_stall), 32'(exp_gnt));
            checkOutput($sformatf("starve c%0d mem_addr", c), 32'(mem_addr),
                        exp_gnt ? 32'h040 : 32'h030);
        end
        tick();
        applyIdle();
        tick();

        // A CPU read is granted while reset is asserted for the same edge.
        // Its rvalid must not appear, and plain CPU priority must follow.
        applyStimulus(1'b1, 4'h0, 12'h050, 32'h0, 1'b0, 4'h0, '0, 32'h0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        applyIdle();
        checkOutput("rst mid-read cpu_rvalid", 32'(cpu_rvalid), 32'd0);
        tick();
        applyStimulus(1'b1, 4'h0, 12'h060, 32'h0, 1'b1, 4'h0, 12'h070, 32'h0);
        checkOutput("post rst cpu_stall", 32'(cpu_stall), 32'd0);
        checkOutput("post rst ldr_gnt", 32'(ldr_gnt), 32'd0);
        tick();
        applyIdle();
        tick();

        // Alternate CPU and loader reads every cycle. Each cycle checks the
        // return of the previous cycle's read.
        for (int i = 0; i <= 6; i++) begin
            if (i < 6) begin
                if (i % 2 == 0)
                    applyStimulus(1'b1, 4'h0, 12'(12'h100 + i), 32'h0, 1'b0, 4'h0, '0, 32'h0);
                else
                    applyStimulus(1'b0, 4'h0, '0, 32'h0, 1'b1, 4'h0, 12'(12'h200 + i), 32'h0);
            end else begin
                applyIdle();
            end
            if (i > 0) begin
                if ((i - 1) % 2 == 0) begin
                    checkOutput($sformatf("alt %0d cpu_rvalid", i), 32'(cpu_rvalid), 32'd1);
                    checkOutput($sformatf("alt %0d ldr_rvalid", i), 32'(ldr_rvalid), 32'd0);
                    checkOutput($sformatf("alt %0d cpu_rdata", i), cpu_rdata,
                                32'hA000_0100 + 32'(i - 1));
                end else begin
                    checkOutput($sformatf("alt %0d cpu_rvalid", i), 32'(cpu_rvalid), 32'd0);
                    checkOutput($sformatf("alt %0d ldr_rvalid", i), 32'(ldr_rvalid), 32'd1);
                    checkOutput($sformatf("alt %0d ldr_rdata", i), ldr_rdata,
                                32'hA000_0200 + 32'(i - 1));
                end
            end
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
